pipe_hold_ctrl: RTL and testbench
=================================

Name: pipe_hold_ctrl

Overview:
- Central hold/flush scheduler for the 5-stage core.
- Collects the jump request from EX, the multi-cycle hold request from EX/MEM and the load-use hazard from ID.
- Drives the PC hold, the IF/ID hold (IF/ID inserts INST_NOP and a zero address while held) and the ID/EX flush.
- Sequences the extra post-jump flush cycles needed because ROM fetch is one cycle late, and keeps stall statistics plus a hold watchdog.

Parameters:
- FLUSH_CYCLES, 2, total cycles IF/ID is held after a taken jump, including the jump cycle (legal range 1..4).
- MAX_HOLD, 64, consecutive hold_req_i cycles after which hold_timeout_o sets.
- CNT_W, 32, width of the stall statistics counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- jump_flag_i  in  1  taken branch/jump from EX.
- jump_addr_i  in  32  target address from EX.
- hold_req_i  in  1  multi-cycle unit busy (div / data bus).
- load_use_i  in  1  load-use hazard detected in ID.
- jump_flag_o  out  1  jump strobe to pc_reg.
- jump_addr_o  out  32  jump target to pc_reg.
- pc_hold_o  out  1  freeze PC.
- hold_flag_o  out  1  hold to if_id.
- id_ex_flush_o  out  1  NOP into id_ex.
- busy_o  out  1  FSM not in RUN.
- stall_cnt_o  out  CNT_W  cycles with pc_hold_o or hold_flag_o high, saturating.
- hold_timeout_o  out  1  sticky watchdog flag.

Behaviour:
- Reset (rst=0, asynchronous): state=RUN, flush counter=0, hold counter=0, stall_cnt_o=0, hold_timeout_o=0. All combinational outputs then evaluate to 0 and jump_addr_o=0.
- Outputs are Mealy: the current-cycle input affects outputs in the same cycle (zero latency). This is required so the IF/ID hold lands on the jump edge.
- State RUN, priority jump > hold > load-use:
  - jump_flag_i=1: jump_flag_o=1, jump_addr_o=jump_addr_i, hold_flag_o=1, id_ex_flush_o=1, pc_hold_o=0. Next state is FLUSH with fcnt=FLUSH_CYCLES-1; if FLUSH_CYCLES==1, stay in RUN.
  - hold_req_i=1 (no jump): pc_hold_o=1, hold_flag_o=1, hcnt=1, next state STALL.
  - load_use_i=1 only: pc_hold_o=1, id_ex_flush_o=1, hold_flag_o=0 for exactly one cycle; stay in RUN.
- State FLUSH:
  - hold_flag_o=1, id_ex_flush_o=1, pc_hold_o=0.
  - fcnt decrements each cycle; exit to RUN on the cycle fcnt reaches 1 (i.e. after FLUSH_CYCLES-1 cycles in FLUSH).
  - A new jump_flag_i in FLUSH restarts the sequence: outputs jump strobe/address and reloads fcnt=FLUSH_CYCLES-1.
  - hold_req_i and load_use_i are ignored in FLUSH (the instructions are squashed).
- State STALL:
  - pc_hold_o=1, hold_flag_o=1, id_ex_flush_o=0.
  - hcnt increments, saturating at MAX_HOLD.
  - When hcnt reaches MAX_HOLD, hold_timeout_o=1 on the next edge and remains set until reset.
  - hold_req_i=0 → RUN next edge, hcnt cleared; the RUN priority rules apply from that edge.
  - jump_flag_i=1 while in STALL: jump wins exactly as in RUN, so STALL → FLUSH.
- jump_addr_o=jump_addr_i whenever jump_flag_o=1, else 0.
- busy_o=1 in FLUSH or STALL.
- stall_cnt_o increments by 1 on each edge where pc_hold_o|hold_flag_o was 1, and holds at all-ones.
- Simultaneous jump_flag_i, hold_req_i and load_use_i: only the jump actions occur.
- Reset mid-FLUSH or mid-STALL: immediate return to reset values, with no residual flush cycles.

Test Plan:
- Reset/idle: assert rst=0 with random inputs, then release with all inputs 0 → every output is 0 and stall_cnt_o=0 for 10 cycles.
- Jump with FLUSH_CYCLES=2: jump_flag_i=1 for one cycle with jump_addr_i=0x0000_0100 →
  - jump cycle: jump_flag_o=1, jump_addr_o=0x100, hold_flag_o=1;
  - next cycle: hold_flag_o=1;
  - after that: hold_flag_o=0; stall_cnt_o=2.
- Back-to-back jumps: jump to 0x40, then jump to 0x80 on the following cycle → FLUSH restarts; hold_flag_o stays high 3 cycles in total; the second strobe carries 0x80.
- Load-use: load_use_i=1 for one cycle → pc_hold_o=1 and id_ex_flush_o=1 for exactly 1 cycle, hold_flag_o=0, busy_o=0.
- Multi-cycle hold: hold_req_i=1 for 5 cycles, with jump_flag_i=1 pulsed on cycle 3 →
  - cycles 1–2: pc_hold_o=1;
  - cycle 3: jump strobe, pc_hold_o=0;
  - afterwards: FLUSH sequence.
- Watchdog: hold_req_i=1 for 70 cycles (MAX_HOLD=64) → hold_timeout_o rises after cycle 64 and stays 1 after hold_req_i drops; async reset clears it mid-stall.

Source files
------------

// File: rtl/pipe_hold_ctrl.sv
// pipe_hold_ctrl: hold/flush scheduler for the 5-stage core with post-jump flush sequencing,
// stall statistics and a hold watchdog. Outputs are Mealy so the IF/ID hold lands on the jump edge.
module pipe_hold_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int MAX_HOLD     = 64,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             jump_flag_i,
    input  logic [31:0]      jump_addr_i,
    input  logic             hold_req_i,
    input  logic             load_use_i,
    output logic             jump_flag_o,
    output logic [31:0]      jump_addr_o,
    output logic             pc_hold_o,
    output logic             hold_flag_o,
    output logic             id_ex_flush_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic             hold_timeout_o
);
    localparam int HW = $clog2(MAX_HOLD + 1);

    typedef enum logic [1:0] {RUN, FLUSH, STALL} state_t;

    state_t           state_q, state_d;
    logic [2:0]       fcnt_q, fcnt_d;
    logic [HW-1:0]    hcnt_q, hcnt_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic             to_q, to_d;
    logic             jmp, hreq, lu, run, fls, stl;

    // Inputs are gated by rst so every output reads 0 while reset is asserted
    always_comb begin
        jmp           = rst & jump_flag_i;
        hreq          = rst & hold_req_i;
        lu            = rst & load_use_i;
        run           = state_q == RUN;
        fls           = state_q == FLUSH;
        stl           = state_q == STALL;
        jump_flag_o   = jmp;
        jump_addr_o   = jmp ? jump_addr_i : 32'd0;
        pc_hold_o     = !jmp & (stl | run & (hreq | lu));
        hold_flag_o   = jmp | fls | stl | run & hreq;
        id_ex_flush_o = jmp | fls | run & !hreq & lu;
        busy_o        = !run;
        state_d       = state_q;
        fcnt_d        = fcnt_q;
        hcnt_d        = hcnt_q;
        if (jmp) begin
            state_d = FLUSH_CYCLES > 1 ? FLUSH : RUN;
            fcnt_d  = 3'(FLUSH_CYCLES - 1);
            hcnt_d  = '0;
        end else if (fls) begin
            fcnt_d  = fcnt_q - 3'(1);
            state_d = fcnt_q <= 3'(1) ? RUN : FLUSH;
        end else if (hreq) begin
            state_d = STALL;
            hcnt_d  = hcnt_q == HW'(MAX_HOLD) ? hcnt_q : hcnt_q + HW'(1);
        end else begin
            state_d = RUN;
            hcnt_d  = '0;
        end
        to_d    = to_q | stl & (hcnt_q == HW'(MAX_HOLD));
        stall_d = (pc_hold_o | hold_flag_o) & ~&stall_q ? stall_q + CNT_W'(1) : stall_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            fcnt_q  <= '0;
            hcnt_q  <= '0;
            stall_q <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            hcnt_q  <= hcnt_d;
            stall_q <= stall_d;
            to_q    <= to_d;
        end
    end

    assign stall_cnt_o    = stall_q;
    assign hold_timeout_o = to_q;
endmodule

// File: tb/tb_pipe_hold_ctrl.sv
// tb_pipe_hold_ctrl: directed scenarios plus randomized traffic against a
// cycle-level reference of the hold/flush rules.
module tb_pipe_hold_ctrl;
    localparam int F   = 2;
    localparam int MAX = 64;

    logic        clk = 0;
    logic        rst = 0;
    logic        jump_flag_i = 0, hold_req_i = 0, load_use_i = 0;
    logic [31:0] jump_addr_i = 0;
    logic        jump_flag_o, pc_hold_o, hold_flag_o, id_ex_flush_o, busy_o, hold_timeout_o;
    logic [31:0] jump_addr_o;
    logic [31:0] stall_cnt_o;
    int          checks = 0, failures = 0;

    // Reference state: remaining flush cycles, length of the current accepted hold run
    int          m_fl, m_hl;
    bit          m_to;
    longint      m_st;

    pipe_hold_ctrl #(.FLUSH_CYCLES(F), .MAX_HOLD(MAX), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
        .hold_req_i(hold_req_i), .load_use_i(load_use_i), .jump_flag_o(jump_flag_o),
        .jump_addr_o(jump_addr_o), .pc_hold_o(pc_hold_o), .hold_flag_o(hold_flag_o),
        .id_ex_flush_o(id_ex_flush_o), .busy_o(busy_o), .stall_cnt_o(stall_cnt_o),
        .hold_timeout_o(hold_timeout_o)
    );

    always #5 clk = ~clk;

    wire [5:0] outs = {jump_flag_o, pc_hold_o, hold_flag_o, id_ex_flush_o, busy_o, hold_timeout_o};

    task automatic drive(input logic j, input logic [31:0] a, input logic h, input logic l);
        jump_flag_i = j;
        jump_addr_i = a;
        hold_req_i  = h;
        load_use_i  = l;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        cyc();
        rst = 0;
        drive(1'($urandom), $urandom, 1'($urandom), 1'($urandom));
        #2;
        drive(0, 0, 0, 0);
        rst = 1;
        m_fl = 0; m_hl = 0; m_to = 0; m_st = 0;
    endtask

    task automatic m_eval(input logic j, input logic h, input logic l, output logic [5:0] e);
        bit b;
        b = m_fl > 0 || m_hl > 0;
        if (j)             e = {1'b1, 1'b0, 1'b1, 1'b1, b, m_to};
        else if (m_fl > 0) e = {1'b0, 1'b0, 1'b1, 1'b1, 1'b1, m_to};
        else if (m_hl > 0) e = {1'b0, 1'b1, 1'b1, 1'b0, 1'b1, m_to};
        else if (h)        e = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, m_to};
        else if (l)        e = {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, m_to};
        else               e = {5'b0, m_to};
    endtask

    task automatic m_adv(input logic j, input logic h, input logic [5:0] e);
        if ((e[4] | e[3]) && m_st < 64'hFFFF_FFFF) m_st++;
        if (m_fl == 0 && m_hl == MAX) m_to = 1;
        if (j) begin m_fl = F - 1; m_hl = 0; end
        else if (m_fl > 0) m_fl--;
        else if (h) m_hl = m_hl < MAX ? m_hl + 1 : MAX;
        else m_hl = 0;
    endtask

    task automatic test_reset();
        cyc();
        rst = 0;
        drive(1, 32'hDEAD_BEEF, 1, 1);
        #1;
        checks++;
        if (outs !== 6'b0 || jump_addr_o !== 0 || stall_cnt_o !== 0) begin
            failures++;
            $display("FAIL reset_active outs=%b addr=%h cnt=%0d exp all 0", outs, jump_addr_o, stall_cnt_o);
        end
        #1;
        drive(0, 0, 0, 0);
        rst = 1;
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++;
            if (outs !== 6'b0 || jump_addr_o !== 0 || stall_cnt_o !== 0) begin
                failures++;
                $display("FAIL reset_idle c%0d outs=%b addr=%h cnt=%0d exp all 0", i, outs, jump_addr_o, stall_cnt_o);
            end
            cyc();
        end
    endtask

    task automatic test_jump();
        logic [5:0]  eo [3] = '{6'b101100, 6'b001110, 6'b000000};
        logic [31:0] ea [3] = '{32'h100, 32'h0, 32'h0};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(i == 0, i == 0 ? 32'h100 : 32'h0, 0, 0);
            #1;
            checks++;
            if (outs !== eo[i] || jump_addr_o !== ea[i]) begin
                failures++;
                $display("FAIL jump c%0d outs=%b addr=%h exp outs=%b addr=%h", i, outs, jump_addr_o, eo[i], ea[i]);
            end
            cyc();
        end
        checks++;
        if (stall_cnt_o !== 2) begin
            failures++;
            $display("FAIL jump_stall_cnt got=%0d exp=2", stall_cnt_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0]  eo [4] = '{6'b101100, 6'b101110, 6'b001110, 6'b000000};
        logic [31:0] ea [4] = '{32'h40, 32'h80, 32'h0, 32'h0};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(i < 2, i == 0 ? 32'h40 : 32'h80, 0, 0);
            #1;
            checks++;
            if (outs !== eo[i] || jump_addr_o !== ea[i]) begin
                failures++;
                $display("FAIL b2b c%0d outs=%b addr=%h exp outs=%b addr=%h", i, outs, jump_addr_o, eo[i], ea[i]);
            end
            cyc();
        end
        checks++;
        if (stall_cnt_o !== 3) begin
            failures++;
            $display("FAIL b2b_stall_cnt got=%0d exp=3", stall_cnt_o);
        end
    endtask

    task automatic test_load_use();
        logic [5:0] eo [3] = '{6'b010100, 6'b000000, 6'b000000};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(0, 32'h0, 0, i == 0);
            #1;
            checks++;
            if (outs !== eo[i]) begin
                failures++;
                $display("FAIL load_use c%0d outs=%b exp=%b", i, outs, eo[i]);
            end
            cyc();
        end
    endtask

    task automatic test_hold_jump();
        logic [5:0] eo [7] = '{6'b011000, 6'b011010, 6'b101110, 6'b001110,
                               6'b011000, 6'b011010, 6'b000000};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            drive(i == 2, 32'h200, i < 5, 0);
            #1;
            checks++;
            if (outs !== eo[i] || jump_addr_o !== (i == 2 ? 32'h200 : 32'h0)) begin
                failures++;
                $display("FAIL hold_jump c%0d outs=%b addr=%h exp=%b", i, outs, jump_addr_o, eo[i]);
            end
            cyc();
        end
        checks++;
        if (stall_cnt_o !== 6) begin
            failures++;
            $display("FAIL hold_jump_stall_cnt got=%0d exp=6", stall_cnt_o);
        end
    endtask

    task automatic test_watchdog();
        do_reset();
        for (int i = 1; i <= 70; i++) begin
            drive(0, 0, 1, 0);
            #1;
            if (i <= MAX || i >= MAX + 2) begin
                checks++;
                if (hold_timeout_o !== (i >= MAX + 2)) begin
                    failures++;
                    $display("FAIL watchdog c%0d timeout=%b exp=%b", i, hold_timeout_o, i >= MAX + 2);
                end
            end
            cyc();
        end
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0);
            #1;
            checks++;
            if (hold_timeout_o !== 1'b1) begin
                failures++;
                $display("FAIL watchdog_sticky c%0d timeout=%b exp=1", i, hold_timeout_o);
            end
            cyc();
        end
        drive(0, 0, 1, 0);
        repeat (4) cyc();
        #2;
        rst = 0;
        #1;
        checks++;
        if (outs !== 6'b0 || stall_cnt_o !== 0) begin
            failures++;
            $display("FAIL watchdog_reset outs=%b cnt=%0d exp 0/0", outs, stall_cnt_o);
        end
        drive(0, 0, 0, 0);
        rst = 1;
        #1;
        checks++;
        if (outs !== 6'b0) begin
            failures++;
            $display("FAIL watchdog_post_reset outs=%b exp=000000", outs);
        end
    endtask

    task automatic test_random();
        logic       j, h, l;
        logic [31:0] a;
        logic [5:0] e;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            j = $urandom_range(7) == 0;
            h = $urandom_range(3) == 0;
            l = $urandom_range(3) == 0;
            a = $urandom;
            drive(j, a, h, l);
            #1;
            m_eval(j, h, l, e);
            checks++;
            if (outs !== e || jump_addr_o !== (j ? a : 32'h0) || stall_cnt_o !== 32'(m_st)) begin
                failures++;
                $display("FAIL random c%0d outs=%b addr=%h cnt=%0d exp outs=%b addr=%h cnt=%0d",
                         i, outs, jump_addr_o, stall_cnt_o, e, j ? a : 32'h0, m_st);
            end
            m_adv(j, h, e);
            cyc();
        end
    endtask

    initial begin
        test_reset();
        test_jump();
        test_back_to_back();
        test_load_use();
        test_hold_jump();
        test_watchdog();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
